// File: rtl/che_line_sched.sv
// che_line_sched: raster pixel scheduler for a two-line ping-pong line buffer.
// Each accepted pixel (x,y) yields, one cycle later, a write of the pixel into
// buffer y[0] (all rows except the last) and a read from buffer ~y[0] (all rows
// except row 0). The buffer return is paired with the delayed pixel, so a
// vertical column pair (cur, pre) appears exactly three cycles after acceptance.
// Ports:
//   clk, rstn                         clock, async active-low reset
//   start_i                           frame start request (honoured in IDLE only)
//   dat_vld_i, dat_i                  input pixel stream, raster order
//   wr_buff_en_o/_dat_o/_num_o        line-buffer write command
//   rd_buff_en_o/_num_o               line-buffer read command
//   buf_vld_i, buf_dat_i              line-buffer read return (1 cycle after read)
//   col_vld_o, col_cur_o, col_pre_o   column output: pixel (x,y) and (x,y-1)
//   col_x_o, col_y_o                  column coordinates
//   done_o                            pulse with the frame's final column
//   err_o                             sticky read-return mismatch flag
module che_line_sched #(
    parameter int unsigned DAT_WD = 9,
    parameter int unsigned SIZ_X  = 64,
    parameter int unsigned SIZ_Y  = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    input  logic                       dat_vld_i,
    input  logic [DAT_WD-1:0]          dat_i,
    output logic                       wr_buff_en_o,
    output logic [DAT_WD-1:0]          wr_buff_dat_o,
    output logic [1:0]                 wr_buff_num_o,
    output logic                       rd_buff_en_o,
    output logic [1:0]                 rd_buff_num_o,
    input  logic                       buf_vld_i,
    input  logic [DAT_WD-1:0]          buf_dat_i,
    output logic                       col_vld_o,
    output logic [DAT_WD-1:0]          col_cur_o,
    output logic [DAT_WD-1:0]          col_pre_o,
    output logic [$clog2(SIZ_X)-1:0]   col_x_o,
    output logic [$clog2(SIZ_Y)-1:0]   col_y_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int unsigned XW = $clog2(SIZ_X);
    localparam int unsigned YW = $clog2(SIZ_Y);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;

    // Stage 1 (T+1): command cycle; pixel data travels in wr_buff_dat_o.
    logic                r_s1_vld;
    logic [XW-1:0]       r_s1_x;
    logic [YW-1:0]       r_s1_y;
    logic                r_s1_last;

    // Stage 2 (T+2): buffer return cycle.
    logic                r_s2_vld;
    logic                r_s2_rd;
    logic [DAT_WD-1:0]   r_s2_dat;
    logic [XW-1:0]       r_s2_x;
    logic [YW-1:0]       r_s2_y;
    logic                r_s2_last;

    logic                w_acc;
    logic                w_x_last;
    logic                w_y_last;

    assign w_acc    = (r_state == ST_RUN) && dat_vld_i;
    assign w_x_last = (r_x == XW'(SIZ_X - 1));
    assign w_y_last = (r_y == YW'(SIZ_Y - 1));

    // FSM, raster counters, three-stage column pipeline and error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_s1_vld      <= 1'b0;
            r_s1_x        <= '0;
            r_s1_y        <= '0;
            r_s1_last     <= 1'b0;
            r_s2_vld      <= 1'b0;
            r_s2_rd       <= 1'b0;
            r_s2_dat      <= '0;
            r_s2_x        <= '0;
            r_s2_y        <= '0;
            r_s2_last     <= 1'b0;
            wr_buff_en_o  <= 1'b0;
            wr_buff_dat_o <= '0;
            wr_buff_num_o <= '0;
            rd_buff_en_o  <= 1'b0;
            rd_buff_num_o <= '0;
            col_vld_o     <= 1'b0;
            col_cur_o     <= '0;
            col_pre_o     <= '0;
            col_x_o       <= '0;
            col_y_o       <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_RUN;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                ST_RUN: begin
                    if (dat_vld_i) begin
                        if (w_x_last) begin
                            r_x <= '0;
                            if (w_y_last) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_y <= r_y + 1'b1;
                            end
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave as the final column is registered, so IDLE coincides with done_o.
                    if (r_s2_vld && r_s2_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Stage 1: buffer commands; last row is never written, row 0 never read.
            r_s1_vld     <= w_acc;
            wr_buff_en_o <= w_acc && !w_y_last;
            rd_buff_en_o <= w_acc && (r_y != '0);
            if (w_acc) begin
                wr_buff_dat_o <= dat_i;
                wr_buff_num_o <= {1'b0, r_y[0]};
                rd_buff_num_o <= {1'b0, ~r_y[0]};
                r_s1_x        <= r_x;
                r_s1_y        <= r_y;
                r_s1_last     <= w_x_last && w_y_last;
            end

            // Stage 2: align pixel with the buffer return.
            r_s2_vld <= r_s1_vld;
            r_s2_rd  <= rd_buff_en_o;
            if (r_s1_vld) begin
                r_s2_dat  <= wr_buff_dat_o;
                r_s2_x    <= r_s1_x;
                r_s2_y    <= r_s1_y;
                r_s2_last <= r_s1_last;
            end

            // Stage 3: column output; row 0 replicates itself as the previous row.
            col_vld_o <= r_s2_vld;
            done_o    <= r_s2_vld && r_s2_last;
            if (r_s2_vld) begin
                col_cur_o <= r_s2_dat;
                col_pre_o <= (r_s2_y != '0) ? buf_dat_i : r_s2_dat;
                col_x_o   <= r_s2_x;
                col_y_o   <= r_s2_y;
            end

            // Sticky until a new frame is started.
            if ((r_state == ST_IDLE) && start_i) begin
                err_o <= 1'b0;
            end else if (buf_vld_i != r_s2_rd) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_che_line_sched.sv
// Directed bench for che_line_sched (4x3 frame) with an ideal ping-pong
// line-buffer responder and a frame-level reference model.
module tb_che_line_sched;

    localparam int unsigned DW = 9;
    localparam int unsigned SX = 4;
    localparam int unsigned SY = 3;

    logic          clk;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic          dat_vld_i = 1'b0;
    logic [DW-1:0] dat_i = '0;
    logic          wr_buff_en_o;
    logic [DW-1:0] wr_buff_dat_o;
    logic [1:0]    wr_buff_num_o;
    logic          rd_buff_en_o;
    logic [1:0]    rd_buff_num_o;
    logic          buf_vld_i;
    logic [DW-1:0] buf_dat_i;
    logic          col_vld_o;
    logic [DW-1:0] col_cur_o;
    logic [DW-1:0] col_pre_o;
    logic [1:0]    col_x_o;
    logic [1:0]    col_y_o;
    logic          done_o;
    logic          err_o;

    che_line_sched #(.DAT_WD(DW), .SIZ_X(SX), .SIZ_Y(SY)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i),
        .dat_vld_i(dat_vld_i), .dat_i(dat_i),
        .wr_buff_en_o(wr_buff_en_o), .wr_buff_dat_o(wr_buff_dat_o),
        .wr_buff_num_o(wr_buff_num_o),
        .rd_buff_en_o(rd_buff_en_o), .rd_buff_num_o(rd_buff_num_o),
        .buf_vld_i(buf_vld_i), .buf_dat_i(buf_dat_i),
        .col_vld_o(col_vld_o), .col_cur_o(col_cur_o), .col_pre_o(col_pre_o),
        .col_x_o(col_x_o), .col_y_o(col_y_o),
        .done_o(done_o), .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Ideal line buffer: one FIFO per buffer number, read data returned next cycle.
    logic [DW-1:0] bq0[$];
    logic [DW-1:0] bq1[$];
    int rd_cnt;
    int drop_at = -1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bq0.delete();
            bq1.delete();
            buf_vld_i <= 1'b0;
            buf_dat_i <= '0;
            rd_cnt    <= 0;
        end else begin
            if (rd_buff_en_o) begin
                if (rd_buff_num_o[0]) buf_dat_i <= (bq1.size() > 0) ? bq1.pop_front() : '0;
                else                  buf_dat_i <= (bq0.size() > 0) ? bq0.pop_front() : '0;
                buf_vld_i <= (rd_cnt != drop_at);
                rd_cnt    <= rd_cnt + 1;
            end else begin
                buf_vld_i <= 1'b0;
            end
            if (wr_buff_en_o) begin
                if (wr_buff_num_o[0]) bq1.push_back(wr_buff_dat_o);
                else                  bq0.push_back(wr_buff_dat_o);
            end
        end
    end

    // Reference model: frame memory and expected-event queues keyed by cycle.
    typedef struct {
        int            due;
        logic          wr;
        logic [1:0]    wn;
        logic [DW-1:0] wd;
        logic          rd;
        logic [1:0]    rn;
    } cmd_t;

    typedef struct {
        int            due;
        logic [DW-1:0] cur;
        logic [DW-1:0] pre;
        logic [1:0]    x;
        logic [1:0]    y;
        logic          done;
    } col_t;

    cmd_t          cq[$];
    col_t          oq[$];
    logic [DW-1:0] mem [SY][SX];
    bit            m_run = 1'b0;
    int            m_idle = 0;
    int            mx = 0;
    int            my = 0;

    logic [DW-1:0] log_cur[$];
    logic [DW-1:0] log_pre[$];
    int            log_done[$];

    task automatic drive(input logic st, input logic v, input logic [DW-1:0] d);
        cmd_t c;
        col_t o;
        @(posedge clk);
        #1;
        start_i   = st;
        dat_vld_i = v;
        dat_i     = d;
        if (v && m_run) begin
            c.due = cyc + 1;
            c.wr  = (my < SY - 1);
            c.wn  = 2'(my % 2);
            c.wd  = d;
            c.rd  = (my > 0);
            c.rn  = 2'(1 - (my % 2));
            cq.push_back(c);
            mem[my][mx] = d;
            o.due  = cyc + 3;
            o.cur  = d;
            o.pre  = (my > 0) ? mem[my-1][mx] : d;
            o.x    = 2'(mx);
            o.y    = 2'(my);
            o.done = (mx == SX - 1) && (my == SY - 1);
            oq.push_back(o);
            if (o.done) begin
                m_run  = 1'b0;
                m_idle = cyc + 3;
            end else if (mx == SX - 1) begin
                mx = 0;
                my = my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        if (st && !m_run && cyc >= m_idle) begin
            m_run = 1'b1;
            mx    = 0;
            my    = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 9'h1FF);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        start_i   = 1'b0;
        dat_vld_i = 1'b0;
        cq.delete();
        oq.delete();
        m_run  = 1'b0;
        m_idle = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Cycle-by-cycle compare of all outputs against the model queues.
    always @(negedge clk) begin
        cmd_t c;
        col_t o;
        if (!rstn) begin
            chk("rst_wr_en",  wr_buff_en_o, 0);
            chk("rst_wr_dat", wr_buff_dat_o, 0);
            chk("rst_rd_en",  rd_buff_en_o, 0);
            chk("rst_col_vld", col_vld_o, 0);
            chk("rst_col_cur", col_cur_o, 0);
            chk("rst_col_pre", col_pre_o, 0);
            chk("rst_done",   done_o, 0);
            chk("rst_err",    err_o, 0);
        end else begin
            if (cq.size() > 0 && cq[0].due == cyc) begin
                c = cq.pop_front();
                chk("wr_en",  wr_buff_en_o, c.wr);
                chk("wr_num", wr_buff_num_o, c.wn);
                chk("wr_dat", wr_buff_dat_o, c.wd);
                chk("rd_en",  rd_buff_en_o, c.rd);
                chk("rd_num", rd_buff_num_o, c.rn);
            end else begin
                chk("wr_en_idle", wr_buff_en_o, 0);
                chk("rd_en_idle", rd_buff_en_o, 0);
            end
            if (oq.size() > 0 && oq[0].due == cyc) begin
                o = oq.pop_front();
                chk("col_vld", col_vld_o, 1);
                chk("col_cur", col_cur_o, o.cur);
                chk("col_pre", col_pre_o, o.pre);
                chk("col_x",   col_x_o, o.x);
                chk("col_y",   col_y_o, o.y);
                chk("done",    done_o, o.done);
            end else begin
                chk("col_vld_idle", col_vld_o, 0);
                chk("done_idle",    done_o, 0);
            end
            if (col_vld_o === 1'b1) begin
                log_cur.push_back(col_cur_o);
                log_pre.push_back(col_pre_o);
                if (done_o === 1'b1) log_done.push_back(log_cur.size() - 1);
            end
        end
    end

    // Hand-computed expectations for a complete 0..11 frame.
    task automatic chk_frame_log();
        logic [DW-1:0] exp_pre [12];
        exp_pre = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd0, 9'd1, 9'd2, 9'd3,
                    9'd4, 9'd5, 9'd6, 9'd7};
        chk("log_cols", log_cur.size(), 12);
        chk("log_done_cnt", log_done.size(), 1);
        if (log_done.size() == 1) chk("log_done_idx", log_done[0], 11);
        for (int i = 0; i < 12 && i < log_cur.size(); i++) begin
            chk("log_cur", log_cur[i], i);
            chk("log_pre", log_pre[i], exp_pre[i]);
        end
        chk("model_drained", cq.size() + oq.size(), 0);
    endtask

    task automatic clear_log();
        log_cur.delete();
        log_pre.delete();
        log_done.delete();
    endtask

    initial begin
        int gaps [12];
        gaps = '{0, 1, 0, 2, 0, 0, 3, 1, 0, 0, 2, 0};

        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Stays idle; pixels without start are ignored.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 9'h055);
        idle(2);

        // Back-to-back frame with a stray start mid-frame.
        clear_log();
        drive(1'b1, 1'b0, 9'h1FF);
        for (int i = 0; i < 12; i++) drive(i == 5, 1'b1, 9'(i));
        drive(1'b0, 1'b1, 9'h0AA);
        idle(6);
        chk_frame_log();
        chk("err_clean_a", err_o, 0);

        // Gapped frame with one dropped read return in row 1.
        clear_log();
        drop_at = rd_cnt + 1;
        drive(1'b1, 1'b0, 9'h1FF);
        for (int i = 0; i < 12; i++) begin
            idle(gaps[i]);
            drive(1'b0, 1'b1, 9'(i));
        end
        idle(6);
        drop_at = -1;
        chk_frame_log();
        chk("err_set", err_o, 1);
        idle(3);
        chk("err_held", err_o, 1);

        // New start clears err; reset after pixel 6 discards the frame.
        drive(1'b1, 1'b0, 9'h1FF);
        idle(1);
        chk("err_cleared", err_o, 0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 9'(i));
        pulse_reset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 9'h033);
        idle(4);

        // Clean frame after reset.
        clear_log();
        drive(1'b1, 1'b0, 9'h1FF);
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 9'(i));
        idle(6);
        chk_frame_log();
        chk("err_clean_d", err_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/che_line_sched.md
CHE_LINE_SCHED -- requirements
Module: che_line_sched

Interface
REQ-001 Parameter DAT_WD, default 9, pixel data width.
REQ-002 Parameter SIZ_X, default 64, pixels per line (>=2).
REQ-003 Parameter SIZ_Y, default 32, lines per frame (>=2).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  single-cycle frame start request.
REQ-007 dat_vld_i  input  1  input pixel valid; no backpressure, one pixel per cycle maximum.
REQ-008 dat_i  input  DAT_WD  input pixel, raster order.
REQ-009 wr_buff_en_o / wr_buff_dat_o / wr_buff_num_o  output  1 / DAT_WD / 2  line-buffer write command.
REQ-010 rd_buff_en_o / rd_buff_num_o  output  1 / 2  line-buffer read command.
REQ-011 buf_vld_i / buf_dat_i  input  1 / DAT_WD  line-buffer read return, one cycle after the read command.
REQ-012 col_vld_o  output  1  column output valid.
REQ-013 col_cur_o / col_pre_o  output  DAT_WD each  pixel at (x,y) / pixel at (x,y-1).
REQ-014 col_x_o / col_y_o  output  $clog2(SIZ_X) / $clog2(SIZ_Y)  column coordinates.
REQ-015 done_o  output  1  single-cycle pulse with the final column of the frame.
REQ-016 err_o  output  1  sticky read-return mismatch flag.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN; reset state is IDLE.
REQ-018 IDLE->RUN on start_i; start_i in RUN or DRAIN is ignored.
REQ-019 A pixel is accepted only when dat_vld_i=1 in RUN; dat_vld_i is ignored in IDLE and DRAIN.
REQ-020 x/y counters SHALL clear on IDLE->RUN; x increments per accepted pixel, wraps SIZ_X-1->0 and increments y.
REQ-021 Acceptance of pixel (SIZ_X-1, SIZ_Y-1) SHALL move RUN->DRAIN; DRAIN->IDLE in the cycle done_o is asserted.
REQ-022 Pixel accepted at cycle T: write/read commands registered, asserted in T+1 only.
REQ-023 Write: wr_buff_en_o=1 iff y<SIZ_Y-1; wr_buff_num_o={1'b0,y[0]}; wr_buff_dat_o=dat_i.
REQ-024 Read: rd_buff_en_o=1 iff y>0; rd_buff_num_o={1'b0,~y[0]}.
REQ-025 The last line is never written and line 0 never read, so both buffers are empty at frame end.
REQ-026 Column outputs SHALL be registered, valid at T+3 (fixed 3-cycle latency), one column per accepted pixel, order preserved.
REQ-027 col_cur_o = pixel at T; col_x_o/col_y_o = its coordinates (delay-matched pipeline).
REQ-028 col_pre_o = buf_dat_i captured at T+2 when y>0; = dat_i of the same pixel when y=0 (edge replication).
REQ-029 done_o=1 together with col_vld_o for column (SIZ_X-1, SIZ_Y-1) only.
REQ-030 err_o SHALL set when buf_vld_i differs from the delayed rd_buff_en_o of the previous cycle; it clears only on IDLE->RUN or reset.
REQ-031 Back-to-back pixels and gapped pixels SHALL behave identically apart from output timing.
REQ-032 Outputs SHALL not be X after reset regardless of buf_dat_i value.

Reset
REQ-033 rstn low SHALL immediately force IDLE, counters 0, err_o 0 and all outputs (command, data, col, done) 0.
REQ-034 Reset mid-frame SHALL discard in-flight pipeline contents; the line buffer shares rstn, so no stale data remains.
REQ-035 After rstn deasserts, the block SHALL stay IDLE until start_i.

Verification (SIZ_X=4, SIZ_Y=3, ideal 1-cycle line-buffer model)
REQ-036 start, 12 back-to-back pixels 0..11 -> 12 columns; cur 0..11; pre row0 = cur, row1 = 0..3, row2 = 4..7; done_o with (3,2).
REQ-037 Pixel 0 at cycle T -> wr_buff_en_o=1, num 0 at T+1; rd_buff_en_o=0; col_vld_o at T+3 with col_pre_o=col_cur_o=0.
REQ-038 Random gaps in dat_vld_i -> same column values; each column exactly 3 cycles after its pixel.
REQ-039 Drop one buf_vld_i during row 1 -> err_o=1 and held; next start_i clears it to 0.
REQ-040 rstn pulse after pixel 6 -> all outputs 0, IDLE; a new start gives a clean 12-column frame identical to REQ-036.
REQ-041 start_i during RUN and dat_vld_i in IDLE -> no effect on counters or outputs.
